system_irq_ctrl: RTL and testbench
==================================

# system_irq_ctrl

Avalon-MM interrupt controller that sits directly downstream of the interval timer and the other peripheral `irq` outputs. It sits between those sources and the RISC-V core's external-interrupt input. It synchronises up to 15 interrupt sources, latches them as level or rising-edge pending bits, and masks them with an enable register. It presents a single `irq_out` plus a claim/complete handshake that returns the highest-priority source ID.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources; legal range 1..15.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `address`  in  3  word address of register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `read_n`  in  1  active-low read strobe; only needed for the claim side effect.
- `writedata`  in  16  write data.
- `readdata`  out  16  registered read data; reset 0.
- `irq_src`  in  NUM_SRC  raw interrupt sources; bit 0 is the interval timer `irq`.
- `irq_out`  out  1  registered interrupt request to the core; reset 0.
- `irq_id`  out  4  registered ID (index+1) of the highest-priority active source, 0 if none; reset 0.

## Operation
- Register map (all registers 16-bit; unused bits read 0 and ignore writes):
  - 0 PENDING: R; write-1-to-clear, edge-mode bits only.
  - 1 ENABLE: RW; reset 0.
  - 2 MODE: RW; reset 0. 1 = rising edge, 0 = level.
  - 3 CLAIM: read = claim; write = complete.
  - 4 STATUS: R; `{11'b0, state==CLAIMED, claimed_id[3:0]}`.
  - 5–7: read 0.
- Write strobe = `chipselect & ~write_n & address==N`; read strobe likewise with `~read_n`.
- Synchroniser: each `irq_src` bit passes a 2-flop synchroniser. Edge detect = `sync2 & ~sync3`.
- Pending, level bits: `pending[i]` follows `sync2[i]` every cycle. W1C and claim have no effect on level bits.
- Pending, edge bits: set on an edge; cleared by W1C or by the claim of that source. If set and clear happen in the same cycle, set wins.
- Active = `pending & enable`. Priority: lowest index wins. `best_id` = index+1 of the winner, or 0 if nothing is active.
- FSM states are IDLE and CLAIMED; reset state is IDLE.
  - IDLE + claim read with `best_id≠0`: latch `claimed_id<=best_id`, clear the edge pending bit, go to CLAIMED.
  - IDLE + claim read with `best_id==0`: return 0, no state change.
  - CLAIMED + claim read: return 0, no change. Claims do not nest.
  - CLAIMED + complete write with `writedata[3:0]==claimed_id`: go to IDLE, clear `claimed_id`.
  - Complete write with a mismatched ID, or a complete write in IDLE: ignored.
- `irq_out <= (state==IDLE) & (best_id≠0)`. `irq_id <= best_id`.
- A MODE change takes effect on the next cycle. Switching edge→level discards the latched edge bit, because pending then follows the level.
- Disabling a source does not clear its pending bit.

## Timing
- Source rising at clk edge E0 propagates as follows: `sync2` is high after E1, `pending` is set after E2, and `irq_out`/`irq_id` are valid after E3. Latency is 3 cycles.
- `readdata` is registered every cycle from the address mux and is valid the cycle after the address is presented.
- The CLAIM value returned is `best_id` from the cycle of the read strobe. The state change occurs on the same edge.
- `irq_out` deasserts on the edge following an accepted claim. It can reassert 1 cycle after an accepted complete, if a source is still active.
- Reset mid-operation returns the FSM to IDLE and clears all registers, synchronisers, and outputs asynchronously.

## Structure
- Package `system_irq_pkg` holds:
  - register address constants (`IRQ_ADDR_PENDING`…`IRQ_ADDR_STATUS`);
  - `IRQ_ID_W = 4`;
  - `MAX_SRC = 15`;
  - the FSM state enum `{IRQ_IDLE, IRQ_CLAIMED}`.
- Sub-module `system_irq_sync` is vector-wide. It contains the 3-flop chain and outputs `level` (sync2) and `rise` (edge pulse).
- The top level contains the registers, the priority encoder, the FSM, and the read mux.

## Test plan
- Timer source: MODE=1 and ENABLE=1 on bit 0; pulse `irq_src[0]` for 1 cycle. Required: `irq_out`=1 three cycles later with `irq_id`=1. A CLAIM read returns 1, and `irq_out` drops next cycle. Complete with 1 puts STATUS back to 0.
- Priority: sources 2 and 5 both pending and enabled. Required: CLAIM returns 3; after completing 3, the next CLAIM returns 6.
- Level mode: bit 1 held high. Required: a W1C of 0x0002 leaves PENDING=0x0002. After the source drops, PENDING clears 2 cycles later.
- Simultaneous events: an edge on bit 0 arrives in the same cycle as a W1C of 0x0001. Required: PENDING[0] stays 1.
- Handshake misuse: in CLAIMED with id 1, complete with 2. Required: state is unchanged and STATUS=0x0011. A second CLAIM read returns 0.
- Reset mid-claim: assert `reset_n`=0 while in CLAIMED. Required: STATUS=0, ENABLE=0, and `irq_out`=0 immediately; no pending survives.

Source files
------------

// File: rtl/system_irq_pkg.sv
// Shared constants, FSM state type and priority helper for the interrupt controller.
package system_irq_pkg;

    localparam int IRQ_ID_W = 4;
    localparam int MAX_SRC  = 15;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 16;

    localparam logic [ADDR_W-1:0] IRQ_ADDR_PENDING = 3'd0;
    localparam logic [ADDR_W-1:0] IRQ_ADDR_ENABLE  = 3'd1;
    localparam logic [ADDR_W-1:0] IRQ_ADDR_MODE    = 3'd2;
    localparam logic [ADDR_W-1:0] IRQ_ADDR_CLAIM   = 3'd3;
    localparam logic [ADDR_W-1:0] IRQ_ADDR_STATUS  = 3'd4;

    typedef enum logic [0:0] {
        IRQ_IDLE    = 1'b0,
        IRQ_CLAIMED = 1'b1
    } irq_state_e;

    // Lowest index wins; returns index+1, or 0 when nothing is active.
    function automatic logic [IRQ_ID_W-1:0] irq_best_id(input logic [MAX_SRC-1:0] act);
        logic [IRQ_ID_W-1:0] id;
        id = 4'd0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                id = 4'(i + 1);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/system_irq_if.sv
// Avalon-MM slave register port of the interrupt controller.
interface system_irq_if;
    import system_irq_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata
    );

endinterface

// File: rtl/system_irq_sync.sv
// Vector-wide 2-flop synchroniser with a third flop for rising-edge detection.
module system_irq_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] sync1_r;
    logic [W-1:0] sync2_r;
    logic [W-1:0] sync3_r;

    // Synchroniser chain; sync3 only exists to delay sync2 by one cycle for edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= {W{1'b0}};
            sync2_r <= {W{1'b0}};
            sync3_r <= {W{1'b0}};
        end else begin
            sync1_r <= d;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign level = sync2_r;
    assign rise  = sync2_r & ~sync3_r;

endmodule

// File: rtl/system_irq_ctrl.sv
// Interrupt controller: pending/enable/mode registers, priority encoder,
// claim/complete FSM and registered Avalon read mux.
module system_irq_ctrl
    import system_irq_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    system_irq_if.slave         bus,
    input  logic [NUM_SRC-1:0]  irq_src,
    output logic                irq_out,
    output logic [IRQ_ID_W-1:0] irq_id
);

    logic [NUM_SRC-1:0]  level_s, rise_s, w1c_s, claim_clr_s, pending_nxt_s;
    logic [NUM_SRC-1:0]  pending_r, enable_r, mode_r;
    logic [MAX_SRC-1:0]  active_s;
    logic [IRQ_ID_W-1:0] best_id_s, claimed_id_r, irq_id_r;
    irq_state_e          state_r, state_nxt_s;
    logic                rd_s, wr_s, claim_rd_s, complete_wr_s;
    logic                claim_acc_s, complete_acc_s, irq_out_r;
    logic [DATA_W-1:0]   rdata_s, readdata_r;

    system_irq_sync #(.W(NUM_SRC)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (irq_src),
        .level   (level_s),
        .rise    (rise_s)
    );

    // Decode bus strobes for the claim/complete handshake.
    always_comb begin
        rd_s          = bus.chipselect & ~bus.read_n;
        wr_s          = bus.chipselect & ~bus.write_n;
        claim_rd_s    = rd_s & (bus.address == IRQ_ADDR_CLAIM);
        complete_wr_s = wr_s & (bus.address == IRQ_ADDR_CLAIM);
    end

    // Mask pending with enable and pick the lowest-index active source.
    always_comb begin
        active_s              = {MAX_SRC{1'b0}};
        active_s[NUM_SRC-1:0] = pending_r & enable_r;
        best_id_s             = irq_best_id(active_s);
    end

    // FSM next state: a claim only lands in IDLE with something active; complete needs the matching ID.
    always_comb begin
        state_nxt_s    = state_r;
        claim_acc_s    = 1'b0;
        complete_acc_s = 1'b0;
        case (state_r)
            IRQ_IDLE: begin
                if (claim_rd_s && (best_id_s != 4'd0)) begin
                    claim_acc_s = 1'b1;
                    state_nxt_s = IRQ_CLAIMED;
                end else begin
                    state_nxt_s = IRQ_IDLE;
                end
            end
            IRQ_CLAIMED: begin
                if (complete_wr_s && (bus.writedata[IRQ_ID_W-1:0] == claimed_id_r)) begin
                    complete_acc_s = 1'b1;
                    state_nxt_s    = IRQ_IDLE;
                end else begin
                    state_nxt_s = IRQ_CLAIMED;
                end
            end
            default: state_nxt_s = IRQ_IDLE;
        endcase
    end

    // Next pending: edge bits set on rise (set beats clear), level bits mirror the synchronised input.
    always_comb begin
        if (wr_s && (bus.address == IRQ_ADDR_PENDING)) begin
            w1c_s = bus.writedata[NUM_SRC-1:0];
        end else begin
            w1c_s = {NUM_SRC{1'b0}};
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_clr_s[i] = claim_acc_s & (best_id_s == 4'(i + 1));
            if (mode_r[i]) begin
                pending_nxt_s[i] = rise_s[i] | (pending_r[i] & ~(w1c_s[i] | claim_clr_s[i]));
            end else begin
                pending_nxt_s[i] = level_s[i];
            end
        end
    end

    // Read mux; CLAIM returns the winner only when the claim is actually accepted.
    always_comb begin
        rdata_s = 16'h0000;
        case (bus.address)
            IRQ_ADDR_PENDING: rdata_s[NUM_SRC-1:0] = pending_r;
            IRQ_ADDR_ENABLE:  rdata_s[NUM_SRC-1:0] = enable_r;
            IRQ_ADDR_MODE:    rdata_s[NUM_SRC-1:0] = mode_r;
            IRQ_ADDR_CLAIM: begin
                if (claim_acc_s) begin
                    rdata_s[IRQ_ID_W-1:0] = best_id_s;
                end else begin
                    rdata_s = 16'h0000;
                end
            end
            IRQ_ADDR_STATUS:  rdata_s = {11'b0, (state_r == IRQ_CLAIMED), claimed_id_r};
            default:          rdata_s = 16'h0000;
        endcase
    end

    // State register, configuration registers, pending bits and claimed ID.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IRQ_IDLE;
            pending_r    <= {NUM_SRC{1'b0}};
            enable_r     <= {NUM_SRC{1'b0}};
            mode_r       <= {NUM_SRC{1'b0}};
            claimed_id_r <= 4'd0;
        end else begin
            state_r   <= state_nxt_s;
            pending_r <= pending_nxt_s;
            if (wr_s && (bus.address == IRQ_ADDR_ENABLE)) begin
                enable_r <= bus.writedata[NUM_SRC-1:0];
            end else begin
                enable_r <= enable_r;
            end
            if (wr_s && (bus.address == IRQ_ADDR_MODE)) begin
                mode_r <= bus.writedata[NUM_SRC-1:0];
            end else begin
                mode_r <= mode_r;
            end
            if (claim_acc_s) begin
                claimed_id_r <= best_id_s;
            end else if (complete_acc_s) begin
                claimed_id_r <= 4'd0;
            end else begin
                claimed_id_r <= claimed_id_r;
            end
        end
    end

    // Registered outputs toward the core and the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_out_r  <= 1'b0;
            irq_id_r   <= 4'd0;
            readdata_r <= 16'h0000;
        end else begin
            irq_out_r  <= (state_r == IRQ_IDLE) && (best_id_s != 4'd0);
            irq_id_r   <= best_id_s;
            readdata_r <= rdata_s;
        end
    end

    assign irq_out      = irq_out_r;
    assign irq_id       = irq_id_r;
    assign bus.readdata = readdata_r;

endmodule

// File: tb/tb_system_irq_ctrl.sv
// Scoreboard bench for system_irq_ctrl: read expectations are queued when a read
// is driven and compared when the registered readdata appears.
module tb_system_irq_ctrl;
    import system_irq_pkg::*;

    localparam int NUM_SRC = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NUM_SRC-1:0] irq_src;
    logic               irq_out;
    logic [3:0]         irq_id;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    system_irq_if bus_if ();

    system_irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .irq_src (irq_src),
        .irq_out (irq_out),
        .irq_id  (irq_id)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives for one edge, returns at the next negedge.
    task automatic reg_write(input logic [2:0] addr, input logic [15:0] data);
        bus_if.address    = addr;
        bus_if.writedata  = data;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic reg_read(input logic [2:0] addr, input logic [15:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_if.address    = addr;
        bus_if.chipselect = 1'b1;
        bus_if.read_n     = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.read_n     = 1'b1;
        check_eq(tag_q.pop_front(), bus_if.readdata, exp_q.pop_front());
    endtask

    // Source high for exactly one clock edge; returns at the negedge after that edge.
    task automatic pulse_src(input logic [NUM_SRC-1:0] mask);
        irq_src = mask;
        @(negedge clk);
        irq_src = {NUM_SRC{1'b0}};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n           = 1'b0;
        irq_src           = {NUM_SRC{1'b0}};
        bus_if.address    = 3'd0;
        bus_if.writedata  = 16'h0000;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.read_n     = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_irq_out", {15'b0, irq_out}, 16'h0000);
        check_eq("rst_irq_id", {12'b0, irq_id}, 16'h0000);
        check_eq("rst_readdata", bus_if.readdata, 16'h0000);
        reset_n = 1'b1;
        @(negedge clk);
        reg_read(IRQ_ADDR_ENABLE, 16'h0000, "rst_enable");
        reg_read(IRQ_ADDR_STATUS, 16'h0000, "rst_status");

        // Timer source, edge mode
        reg_write(IRQ_ADDR_MODE, 16'h0001);
        reg_write(IRQ_ADDR_ENABLE, 16'h0001);
        pulse_src(8'h01);
        @(negedge clk);
        @(negedge clk);
        check_eq("timer_lat2_irq_out", {15'b0, irq_out}, 16'h0000);
        @(negedge clk);
        check_eq("timer_lat3_irq_out", {15'b0, irq_out}, 16'h0001);
        check_eq("timer_irq_id", {12'b0, irq_id}, 16'h0001);
        reg_read(IRQ_ADDR_CLAIM, 16'h0001, "timer_claim");
        check_eq("timer_irq_out_claim_edge", {15'b0, irq_out}, 16'h0001);
        @(negedge clk);
        check_eq("timer_irq_out_dropped", {15'b0, irq_out}, 16'h0000);
        reg_read(IRQ_ADDR_STATUS, 16'h0011, "timer_status_claimed");
        reg_write(IRQ_ADDR_CLAIM, 16'h0001);
        reg_read(IRQ_ADDR_STATUS, 16'h0000, "timer_status_done");

        // Priority between sources 2 and 5
        reg_write(IRQ_ADDR_MODE, 16'h0025);
        reg_write(IRQ_ADDR_ENABLE, 16'h0025);
        pulse_src(8'h24);
        repeat (3) @(negedge clk);
        check_eq("prio_irq_id", {12'b0, irq_id}, 16'h0003);
        reg_read(IRQ_ADDR_CLAIM, 16'h0003, "prio_claim_first");
        reg_write(IRQ_ADDR_CLAIM, 16'h0003);
        reg_read(IRQ_ADDR_CLAIM, 16'h0006, "prio_claim_second");
        reg_read(IRQ_ADDR_STATUS, 16'h0016, "prio_status");
        reg_write(IRQ_ADDR_CLAIM, 16'h0006);
        reg_read(IRQ_ADDR_STATUS, 16'h0000, "prio_status_done");

        // Level mode on bit 1, disabled
        reg_write(IRQ_ADDR_MODE, 16'h0000);
        reg_write(IRQ_ADDR_ENABLE, 16'h0000);
        irq_src = 8'h02;
        repeat (4) @(negedge clk);
        reg_read(IRQ_ADDR_PENDING, 16'h0002, "level_pending");
        reg_write(IRQ_ADDR_PENDING, 16'h0002);
        reg_read(IRQ_ADDR_PENDING, 16'h0002, "level_w1c_ignored");
        check_eq("level_disabled_irq_out", {15'b0, irq_out}, 16'h0000);
        irq_src = 8'h00;
        @(negedge clk);
        reg_read(IRQ_ADDR_PENDING, 16'h0002, "level_drop_e1");
        reg_read(IRQ_ADDR_PENDING, 16'h0002, "level_drop_e2");
        reg_read(IRQ_ADDR_PENDING, 16'h0000, "level_drop_e3");

        // Edge and W1C on bit 0 in the same cycle
        reg_write(IRQ_ADDR_MODE, 16'h0001);
        irq_src = 8'h01;
        @(negedge clk);
        irq_src = 8'h00;
        @(negedge clk);
        reg_write(IRQ_ADDR_PENDING, 16'h0001);
        reg_read(IRQ_ADDR_PENDING, 16'h0001, "simul_set_wins");
        reg_write(IRQ_ADDR_PENDING, 16'h0001);
        reg_read(IRQ_ADDR_PENDING, 16'h0000, "w1c_clears");

        // Handshake misuse
        reg_write(IRQ_ADDR_ENABLE, 16'h0001);
        pulse_src(8'h01);
        repeat (3) @(negedge clk);
        reg_read(IRQ_ADDR_CLAIM, 16'h0001, "misuse_claim");
        reg_write(IRQ_ADDR_CLAIM, 16'h0002);
        reg_read(IRQ_ADDR_STATUS, 16'h0011, "misuse_status");
        pulse_src(8'h01);
        repeat (3) @(negedge clk);
        check_eq("misuse_irq_id", {12'b0, irq_id}, 16'h0001);
        check_eq("misuse_irq_out_held", {15'b0, irq_out}, 16'h0000);
        reg_read(IRQ_ADDR_CLAIM, 16'h0000, "misuse_nested_claim");
        reg_read(IRQ_ADDR_STATUS, 16'h0011, "misuse_status_again");

        // Reset while claimed
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rstmid_irq_out", {15'b0, irq_out}, 16'h0000);
        check_eq("rstmid_irq_id", {12'b0, irq_id}, 16'h0000);
        check_eq("rstmid_readdata", bus_if.readdata, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        reg_read(IRQ_ADDR_STATUS, 16'h0000, "rstmid_status");
        reg_read(IRQ_ADDR_ENABLE, 16'h0000, "rstmid_enable");
        reg_read(IRQ_ADDR_PENDING, 16'h0000, "rstmid_pending");
        reg_read(IRQ_ADDR_MODE, 16'h0000, "rstmid_mode");
        check_eq("rstmid_irq_out_after", {15'b0, irq_out}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
